uc_atualiza_tiros: RTL and testbench

Control unit that sweeps every slot of the shot memory once per game tick. For each loaded shot it either advances the shot or frees the slot; out-of-screen and asteroid-hit shots are freed. It sits beside the shot-registration control unit on the same shot memory and datapath, and is started by the main game control unit once per frame. It drives the slot address, move, remove and write-enable strobes, and signals completion with a one-cycle done pulse.

---
 rtl/uc_atualiza_tiros_if.sv | 38 +++
 rtl/uc_atualiza_tiros.sv | 119 +++++++++++
 tb/tb_uc_atualiza_tiros.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_atualiza_tiros_if.sv
// Handshake/bus bundle between the shot-update control unit and its datapath.
// master: game/datapath side; slave: the control unit.
interface uc_atualiza_tiros_if #(
  parameter int N_TIROS = 16
);
  localparam int W = $clog2(N_TIROS);

  logic         atualiza_tiros;
  logic         loaded_tiro;
  logic         fora_limite;
  logic         colisao_tiro;
  logic [W-1:0] endereco_tiro;
  logic         le_mem_tiro;
  logic         move_tiro;
  logic         remove_tiro;
  logic         enable_mem_tiro;
  logic         tiros_atualizados;
  logic [W:0]   n_removidos;
  logic [3:0]   db_estado_atualiza_tiros;

  modport master (
    output atualiza_tiros, loaded_tiro,
    output fora_limite, colisao_tiro,
    input  endereco_tiro, le_mem_tiro,
    input  move_tiro, remove_tiro,
    input  enable_mem_tiro, tiros_atualizados,
    input  n_removidos, db_estado_atualiza_tiros
  );

  modport slave (
    input  atualiza_tiros, loaded_tiro,
    input  fora_limite, colisao_tiro,
    output endereco_tiro, le_mem_tiro,
    output move_tiro, remove_tiro,
    output enable_mem_tiro, tiros_atualizados,
    output n_removidos, db_estado_atualiza_tiros
  );
endinterface

// File: rtl/uc_atualiza_tiros.sv
// Shot-memory sweep control unit: advances or frees every loaded slot per tick.
// Optional removed-shot counter: UC_ATUALIZA_TIROS_CONTA_REMOVIDOS_EN.
module uc_atualiza_tiros #(
  parameter int N_TIROS = 16
) (
  input logic clock,
  input logic reset,
  uc_atualiza_tiros_if.slave bus
);
  localparam int W = $clog2(N_TIROS);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    ESPERA     = 4'h1,
    ZERA       = 4'h2,
    LE         = 4'h3,
    VERIFICA   = 4'h4,
    MOVE       = 4'h5,
    REMOVE     = 4'h6,
    INCREMENTA = 4'h7,
    SINALIZA   = 4'h8,
    ERRO       = 4'hF
  } estado_t;

  estado_t      estado_q, estado_d;
  logic [W-1:0] end_q, end_d;
  logic         ultimo;

  assign ultimo = (end_q == W'(N_TIROS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      end_q    <= '0;
    end else begin
      estado_q <= estado_d;
      end_q    <= end_d;
    end
  end

  always_comb begin
    estado_d = ERRO;
    unique case (estado_q)
      INICIAL:  estado_d = ESPERA;
      ESPERA:   estado_d = bus.atualiza_tiros
                         ? ZERA : ESPERA;
      ZERA:     estado_d = LE;
      LE:       estado_d = VERIFICA;
      VERIFICA: begin
        if (!bus.loaded_tiro)
          estado_d = INCREMENTA;
        else if (bus.fora_limite || bus.colisao_tiro)
          estado_d = REMOVE;
        else
          estado_d = MOVE;
      end
      MOVE:       estado_d = INCREMENTA;
      REMOVE:     estado_d = INCREMENTA;
      INCREMENTA: estado_d = ultimo ? SINALIZA : LE;
      SINALIZA:   estado_d = ESPERA;
      default:    estado_d = (estado_q == ERRO)
                           ? INICIAL : ERRO;
    endcase
  end

  // Index holds at the last slot after the sweep; only zera clears it.
  always_comb begin
    end_d = end_q;
    if (estado_q == ZERA)
      end_d = '0;
    else if (estado_q == INCREMENTA && !ultimo)
      end_d = end_q + W'(1);
  end

  always_comb begin
    bus.le_mem_tiro       = 1'b0;
    bus.move_tiro         = 1'b0;
    bus.remove_tiro       = 1'b0;
    bus.enable_mem_tiro   = 1'b0;
    bus.tiros_atualizados = 1'b0;
    unique case (estado_q)
      LE, VERIFICA: bus.le_mem_tiro = 1'b1;
      MOVE: begin
        bus.move_tiro       = 1'b1;
        bus.enable_mem_tiro = 1'b1;
      end
      REMOVE: begin
        bus.remove_tiro     = 1'b1;
        bus.enable_mem_tiro = 1'b1;
      end
      SINALIZA: bus.tiros_atualizados = 1'b1;
      default: ;
    endcase
  end

  assign bus.endereco_tiro            = end_q;
  assign bus.db_estado_atualiza_tiros = estado_q;

`ifdef UC_ATUALIZA_TIROS_CONTA_REMOVIDOS_EN
  logic [W:0] n_rem_q, n_rem_d;

  always_ff @(posedge clock) begin
    if (reset) n_rem_q <= '0;
    else       n_rem_q <= n_rem_d;
  end

  always_comb begin
    n_rem_d = n_rem_q;
    if (estado_q == ZERA)
      n_rem_d = '0;
    else if (estado_q == REMOVE)
      n_rem_d = n_rem_q + (W+1)'(1);
  end

  assign bus.n_removidos = n_rem_q;
`else
  assign bus.n_removidos = '0;
`endif
endmodule

// File: tb/tb_uc_atualiza_tiros.sv
// Self-checking bench for uc_atualiza_tiros with N_TIROS=4.
// Slot contents come from bench arrays; expectations from a per-slot model.
module tb_uc_atualiza_tiros;
  localparam int N = 4;
  localparam int W = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] ld = '0;
  logic [N-1:0] fl = '0;
  logic [N-1:0] co = '0;
  int n_checks = 0;
  int n_fail   = 0;

  uc_atualiza_tiros_if #(.N_TIROS(N)) bus();

  assign bus.loaded_tiro  = ld[bus.endereco_tiro];
  assign bus.fora_limite  = fl[bus.endereco_tiro];
  assign bus.colisao_tiro = co[bus.endereco_tiro];

  uc_atualiza_tiros #(.N_TIROS(N)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] strobes();
    return {bus.le_mem_tiro, bus.move_tiro,
            bus.remove_tiro, bus.enable_mem_tiro,
            bus.tiros_atualizados};
  endfunction

  task automatic test_reset();
    bus.atualiza_tiros = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.db_estado_atualiza_tiros !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d want 0",
               bus.db_estado_atualiza_tiros);
    end
    n_checks++;
    if (strobes() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 0", strobes());
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.db_estado_atualiza_tiros !== 4'd1) begin
      n_fail++;
      $display("FAIL idle_state got %0d want 1",
               bus.db_estado_atualiza_tiros);
    end
    n_checks++;
    if (strobes() !== 5'b0) begin
      n_fail++;
      $display("FAIL idle_strobes got %b want 0", strobes());
    end
    n_checks++;
    if (bus.endereco_tiro !== W'(0)) begin
      n_fail++;
      $display("FAIL idle_addr got %0d want 0", bus.endereco_tiro);
    end
    n_checks++;
    if (bus.n_removidos !== '0) begin
      n_fail++;
      $display("FAIL idle_nrem got %0d want 0", bus.n_removidos);
    end
  endtask

  task automatic test_sweep(input logic [N-1:0] l,
                            input logic [N-1:0] f,
                            input logic [N-1:0] c,
                            input string name);
    int exp_l = 0, exp_r = 0;
    logic [N-1:0] exp_mv = '0, exp_rm = '0;
    logic [N-1:0] got_mv = '0, got_rm = '0;
    int mv_cnt = 0, rm_cnt = 0, le_cnt = 0, en_cnt = 0;
    int done_cnt = 0, done_cyc = -1, exp_nrem;
    bit fin = 0;
    ld = l; fl = f; co = c;
    for (int i = 0; i < N; i++) begin
      if (l[i]) begin
        exp_l++;
        if (f[i] || c[i]) begin exp_rm[i] = 1'b1; exp_r++; end
        else exp_mv[i] = 1'b1;
      end
    end
`ifdef UC_ATUALIZA_TIROS_CONTA_REMOVIDOS_EN
    exp_nrem = exp_r;
`else
    exp_nrem = 0;
`endif
    @(negedge clk);
    bus.atualiza_tiros = 1'b1;
    @(posedge clk);
    #1 bus.atualiza_tiros = 1'b0;
    for (int j = 1; j <= 4 * N + 8 && !fin; j++) begin
      @(negedge clk);
      if (bus.move_tiro) begin
        mv_cnt++; got_mv[bus.endereco_tiro] = 1'b1;
      end
      if (bus.remove_tiro) begin
        rm_cnt++; got_rm[bus.endereco_tiro] = 1'b1;
      end
      if (bus.le_mem_tiro) le_cnt++;
      if (bus.enable_mem_tiro) en_cnt++;
      if (bus.tiros_atualizados) begin
        done_cnt++; done_cyc = j;
      end
      if (done_cnt > 0 && bus.db_estado_atualiza_tiros == 4'd1)
        fin = 1;
    end
    n_checks++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout got no return to espera want return", name);
    end
    n_checks++;
    if (done_cyc != 3 * N + 2 + exp_l) begin
      n_fail++;
      $display("FAIL %s done_cycle got %0d want %0d",
               name, done_cyc, 3 * N + 2 + exp_l);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_count got %0d want 1", name, done_cnt);
    end
    n_checks++;
    if (got_mv !== exp_mv || mv_cnt != exp_l - exp_r) begin
      n_fail++;
      $display("FAIL %s moves got %b/%0d want %b/%0d",
               name, got_mv, mv_cnt, exp_mv, exp_l - exp_r);
    end
    n_checks++;
    if (got_rm !== exp_rm || rm_cnt != exp_r) begin
      n_fail++;
      $display("FAIL %s removes got %b/%0d want %b/%0d",
               name, got_rm, rm_cnt, exp_rm, exp_r);
    end
    n_checks++;
    if (le_cnt != 2 * N || en_cnt != exp_l) begin
      n_fail++;
      $display("FAIL %s rd_wr_cycles got %0d/%0d want %0d/%0d",
               name, le_cnt, en_cnt, 2 * N, exp_l);
    end
    n_checks++;
    if (bus.n_removidos !== (W+1)'(exp_nrem)) begin
      n_fail++;
      $display("FAIL %s n_removidos got %0d want %0d",
               name, bus.n_removidos, exp_nrem);
    end
    n_checks++;
    if (bus.endereco_tiro !== W'(N - 1)) begin
      n_fail++;
      $display("FAIL %s final_addr got %0d want %0d",
               name, bus.endereco_tiro, N - 1);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    int dones = 0;
    ld = 4'b0010; fl = '0; co = '0;
    @(negedge clk);
    bus.atualiza_tiros = 1'b1;
    @(posedge clk);
    #1 bus.atualiza_tiros = 1'b0;
    for (int j = 0; j < 30 && !hit; j++) begin
      @(negedge clk);
      if (bus.move_tiro && bus.endereco_tiro == W'(1)) hit = 1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_reach got no move@1 want move@1");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.db_estado_atualiza_tiros !== 4'd0 ||
        bus.endereco_tiro !== W'(0) ||
        bus.n_removidos !== '0) begin
      n_fail++;
      $display("FAIL rst_mid got st%0d a%0d n%0d want st0 a0 n0",
               bus.db_estado_atualiza_tiros,
               bus.endereco_tiro, bus.n_removidos);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (bus.tiros_atualizados) dones++;
    end
    n_checks++;
    if (dones != 0 || bus.db_estado_atualiza_tiros !== 4'd1) begin
      n_fail++;
      $display("FAIL rst_mid_after got done%0d st%0d want done0 st1",
               dones, bus.db_estado_atualiza_tiros);
    end
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    logic [3:0] prev = 4'd1;
    logic [3:0] prev2 = 4'd1;
    ld = N'($urandom); fl = N'($urandom); co = N'($urandom);
    @(negedge clk);
    bus.atualiza_tiros = 1'b1;
    for (int j = 0; j < 150 && gaps < 2; j++) begin
      @(negedge clk);
      if (prev2 == 4'd8 && prev == 4'd1) begin
        gaps++;
        n_checks++;
        if (bus.db_estado_atualiza_tiros !== 4'd2) begin
          n_fail++;
          $display("FAIL b2b_restart got %0d want 2",
                   bus.db_estado_atualiza_tiros);
        end
      end else if (prev == 4'd8) begin
        n_checks++;
        if (bus.db_estado_atualiza_tiros !== 4'd1) begin
          n_fail++;
          $display("FAIL b2b_espera got %0d want 1",
                   bus.db_estado_atualiza_tiros);
        end
      end
      prev2 = prev;
      prev  = bus.db_estado_atualiza_tiros;
    end
    n_checks++;
    if (gaps != 2) begin
      n_fail++;
      $display("FAIL b2b_gaps got %0d want 2", gaps);
    end
    bus.atualiza_tiros = 1'b0;
    for (int j = 0; j < 40 &&
         bus.db_estado_atualiza_tiros != 4'd1; j++)
      @(negedge clk);
    n_checks++;
    if (bus.db_estado_atualiza_tiros !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_drain got %0d want 1",
               bus.db_estado_atualiza_tiros);
    end
  endtask

  initial begin
    bus.atualiza_tiros = 1'b0;
    test_reset();
    test_sweep(4'b0000, 4'b0000, 4'b0000, "empty");
    test_sweep(4'b1010, 4'b1000, 4'b0000, "slots13");
    test_sweep(4'b0100, 4'b0100, 4'b0100, "both_hit");
    test_sweep(4'b1111, 4'b0011, 4'b0101, "full");
    test_sweep(4'b0000, 4'b1111, 4'b1111, "unloaded_hits");
    for (int k = 0; k < 8; k++)
      test_sweep(N'($urandom), N'($urandom), N'($urandom), "random");
    test_reset_mid();
    test_back_to_back();
    test_sweep(4'b0110, 4'b0000, 4'b0010, "final");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
